// File: rtl/uart_rx_feeder.sv
// ---------------------------------------------------------------------------
// uart_rx_feeder
//
// Receives UART frames on an asynchronous serial line and hands each good
// byte to a downstream CDC register through a one-byte hold register and a
// single-cycle write strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   undefined : 8N1 frames, parity_err tied low
//   defined   : 8E1 frames, even-parity bit checked after the data bits
//
// Parameters
//   CLKS_PER_BIT : clk_in cycles per UART bit (4..65535)
//
// Ports
//   clk_in      in   write-domain clock, rising edge
//   reset       in   synchronous, active-high reset
//   rx          in   asynchronous serial line, idle high
//   wr_en       out  one-cycle write strobe to the downstream register
//   wr_data     out  received byte, valid while wr_en=1, held between writes
//   busy        in   downstream full flag, no write launched while high
//   framing_err out  one-cycle pulse, stop bit sampled low
//   overrun     out  one-cycle pulse, byte dropped because hold was full
//   parity_err  out  one-cycle pulse, parity mismatch (0 when compiled out)
// ---------------------------------------------------------------------------
module uart_rx_feeder #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       rx,
    output logic       wr_en,
    output logic [7:0] wr_data,
    input  logic       busy,
    output logic       framing_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic        rxMeta_q, rxSync_q, rxPrev_q;
    logic [1:0]  settle_q;
    logic [15:0] clkCnt_q, clkCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        holdValid_q, holdValid_d;
    logic [7:0]  holdData_q, holdData_d;
    logic        wrEn_q, wrEn_d;
    logic [7:0]  wrData_q, wrData_d;
    logic [1:0]  gap_q, gap_d;
    logic        framingErr_q, framingErr_d;
    logic        overrun_q, overrun_d;
    logic        fallEdge, accept, frameBad, fire;
`ifdef UART_RX_PARITY_EN
    logic        parityBad_q, parityBad_d;
    logic        parityErr_q, parityErr_d;
    logic        parityHit;
`endif

    // A falling edge only counts once the synchronizer and the edge flop
    // hold real line samples (three edges after reset). The flops come out
    // of reset at 1, so without this a line held low through reset would
    // look like a fresh start bit.
    assign fallEdge = (settle_q == 2'd3) && rxPrev_q && !rxSync_q;

    // Frame decoder. Start bit is re-checked at mid-bit to reject glitches;
    // every later bit is sampled one full bit period after the previous
    // sample, so all samples land near bit centres.
    always_comb begin
        state_d  = state_q;
        clkCnt_d = clkCnt_q + 16'd1;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        accept   = 1'b0;
        frameBad = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBad_d = parityBad_q;
        parityHit   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                clkCnt_d = 16'd0;
                bitIdx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                parityBad_d = 1'b0;
`endif
                if (fallEdge) begin
                    state_d = START;
                end
            end
            START: begin
                if (clkCnt_q == HALF_CNT) begin
                    clkCnt_d = 16'd0;
                    state_d  = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clkCnt_q == LAST_CNT) begin
                    clkCnt_d = 16'd0;
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clkCnt_q == LAST_CNT) begin
                    clkCnt_d    = 16'd0;
                    parityBad_d = rxSync_q ^ (^shift_q);
                    state_d     = STOP;
                end
            end
`endif
            STOP: begin
                if (clkCnt_q == LAST_CNT) begin
                    clkCnt_d = 16'd0;
                    state_d  = IDLE;
                    if (!rxSync_q) begin
                        frameBad = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (parityBad_q) begin
                        parityHit = 1'b1;
`endif
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                clkCnt_d = 16'd0;
            end
        endcase
    end

    // Hold register and write launcher. A write goes out whenever a byte is
    // available (already held, or accepted right now) and the downstream is
    // not busy and the post-write gap has expired. A freshly accepted byte
    // with an empty hold goes straight out, which gives the one-cycle
    // latency after the stop sample. The gap counter keeps two quiet cycles
    // after every strobe so the downstream busy can rise.
    always_comb begin
        holdValid_d  = holdValid_q;
        holdData_d   = holdData_q;
        wrEn_d       = 1'b0;
        wrData_d     = wrData_q;
        gap_d        = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
        overrun_d    = 1'b0;
        framingErr_d = frameBad;
`ifdef UART_RX_PARITY_EN
        parityErr_d  = parityHit;
`endif
        fire = (holdValid_q || accept) && !busy && (gap_q == 2'd0);
        if (fire) begin
            wrEn_d = 1'b1;
            gap_d  = 2'd2;
            if (holdValid_q) begin
                wrData_d    = holdData_q;
                holdValid_d = accept;
                if (accept) begin
                    holdData_d = shift_q;
                end
            end else begin
                wrData_d = shift_q;
            end
        end else if (accept) begin
            if (holdValid_q) begin
                overrun_d = 1'b1;
            end else begin
                holdValid_d = 1'b1;
                holdData_d  = shift_q;
            end
        end
    end

    // State register. Reset wins over everything, including a frame in
    // flight, and parks the synchronizer at the idle (high) level.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rxMeta_q     <= 1'b1;
            rxSync_q     <= 1'b1;
            rxPrev_q     <= 1'b1;
            settle_q     <= 2'd0;
            state_q      <= IDLE;
            clkCnt_q     <= 16'd0;
            bitIdx_q     <= 3'd0;
            shift_q      <= 8'h00;
            holdValid_q  <= 1'b0;
            holdData_q   <= 8'h00;
            wrEn_q       <= 1'b0;
            wrData_q     <= 8'h00;
            gap_q        <= 2'd0;
            framingErr_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBad_q  <= 1'b0;
            parityErr_q  <= 1'b0;
`endif
        end else begin
            rxMeta_q     <= rx;
            rxSync_q     <= rxMeta_q;
            rxPrev_q     <= rxSync_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            state_q      <= state_d;
            clkCnt_q     <= clkCnt_d;
            bitIdx_q     <= bitIdx_d;
            shift_q      <= shift_d;
            holdValid_q  <= holdValid_d;
            holdData_q   <= holdData_d;
            wrEn_q       <= wrEn_d;
            wrData_q     <= wrData_d;
            gap_q        <= gap_d;
            framingErr_q <= framingErr_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parityBad_q  <= parityBad_d;
            parityErr_q  <= parityErr_d;
`endif
        end
    end

    assign wr_en       = wrEn_q;
    assign wr_data     = wrData_q;
    assign framing_err = framingErr_q;
    assign overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parityErr_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_feeder
//
// Self-checking bench for uart_rx_feeder at CLKS_PER_BIT=16. A frame-level
// model predicts which bytes must be written and how many error pulses of
// each kind must appear; a negedge monitor compares every write and pulse
// against it. Directed literal expectations pin latency and data values.
// Builds with or without UART_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx_feeder;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit ParityOn = 1'b1;
`else
    localparam bit ParityOn = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       busy   = 1'b0;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       framing_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int frameStartCyc = 0;
    int lastWrCyc = -100;
    int lastWrData = -1;
    int busyFallCyc = 0;

    logic [7:0] expQ[$];
    int  expFraming = 0, expOverrun = 0, expParity = 0;
    int  obsFraming = 0, obsOverrun = 0, obsParity = 0;
    bit  modelHeld = 1'b0;
    logic busyPrev = 1'b0;
    logic framingPrev = 1'b0, overrunPrev = 1'b0, parityPrev = 1'b0;

    uart_rx_feeder #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .rx          (rx),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .busy        (busy),
        .framing_err (framing_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    // Free-running clock and cycle counter used for latency checks.
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Frame-level model: decides the fate of one frame from its bits and
    // the current busy level, without any notion of cycles.
    task automatic modelFrame(input logic [7:0] data, input logic stopBit,
                              input logic parBit);
        if (!stopBit) begin
            expFraming++;
        end else if (ParityOn && (parBit != ^data)) begin
            expParity++;
        end else if (busy && modelHeld) begin
            expOverrun++;
        end else begin
            expQ.push_back(data);
            if (busy) modelHeld = 1'b1;
        end
    endtask

    // Drives one complete UART frame, optionally pulsing reset in the
    // middle of a chosen data bit, then leaves the line idle for a while.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input logic parBit, input int resetAtBit,
                                 input bit useModel);
        if (useModel) modelFrame(data, stopBit, parBit);
        @(posedge clk_in);
        #1;
        rx = 1'b0;
        frameStartCyc = cyc;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == resetAtBit) begin
                waitCycles(4);
                reset = 1'b1;
                waitCycles(3);
                reset = 1'b0;
                waitCycles(CPB - 7);
            end else begin
                waitCycles(CPB);
            end
        end
        if (ParityOn) begin
            rx = parBit;
            waitCycles(CPB);
        end
        rx = stopBit;
        waitCycles(CPB);
        rx = 1'b1;
        waitCycles(20);
    endtask

    task automatic setBusy(input logic level);
        @(posedge clk_in);
        #1;
        busy = level;
        if (!level) begin
            modelHeld = 1'b0;
            busyFallCyc = cyc;
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, " writes pending"}, 32'(expQ.size()), 32'd0);
        checkOutput({tag, " framing_err count"}, 32'(obsFraming), 32'(expFraming));
        checkOutput({tag, " overrun count"}, 32'(obsOverrun), 32'(expOverrun));
        checkOutput({tag, " parity_err count"}, 32'(obsParity), 32'(expParity));
    endtask

    // Monitor: every write is matched against the model queue, writes must
    // respect busy and the two-cycle gap, and error pulses must be one
    // cycle wide.
    always @(negedge clk_in) begin
        if (wr_en) begin
            if (expQ.size() == 0) begin
                checkOutput("wr_en with nothing expected", {31'd0, wr_en}, 32'd0);
            end else begin
                checkOutput("wr_data", {24'd0, wr_data}, {24'd0, expQ.pop_front()});
            end
            checkOutput("wr_en launched while busy", {31'd0, busyPrev}, 32'd0);
            checkOutput("wr_en gap of two cycles", 32'((cyc - lastWrCyc) >= 3), 32'd1);
            lastWrCyc  = cyc;
            lastWrData = int'(wr_data);
        end
        if (framing_err) begin
            obsFraming++;
            if (framingPrev) checkOutput("framing_err width", {31'd0, framingPrev}, 32'd0);
        end
        if (overrun) begin
            obsOverrun++;
            if (overrunPrev) checkOutput("overrun width", {31'd0, overrunPrev}, 32'd0);
        end
        if (parity_err) begin
            obsParity++;
            if (parityPrev) checkOutput("parity_err width", {31'd0, parityPrev}, 32'd0);
        end
        busyPrev    = busy;
        framingPrev = framing_err;
        overrunPrev = overrun;
        parityPrev  = parity_err;
    end

    // Directed scenario sequence.
    initial begin
        waitCycles(3);
        reset = 1'b0;
        @(negedge clk_in);
        checkOutput("reset wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("reset wr_data", {24'd0, wr_data}, 32'h00);
        checkOutput("reset framing_err", {31'd0, framing_err}, 32'd0);
        checkOutput("reset overrun", {31'd0, overrun}, 32'd0);
        checkOutput("reset parity_err", {31'd0, parity_err}, 32'd0);
        waitCycles(10);

        $display("[TB] single byte 0xA5, busy low");
        applyStimulus(8'hA5, 1'b1, ^8'hA5, -1, 1'b1);
        checkOutput("0xA5 write latency", 32'(lastWrCyc - frameStartCyc),
                    ParityOn ? 32'd171 : 32'd155);
        checkOutput("0xA5 written value", 32'(lastWrData), 32'hA5);
        checkCounts("0xA5");

        $display("[TB] 0x3C held behind busy");
        setBusy(1'b1);
        applyStimulus(8'h3C, 1'b1, ^8'h3C, -1, 1'b1);
        waitCycles(80);
        checkOutput("0x3C still held", 32'(expQ.size()), 32'd1);
        setBusy(1'b0);
        waitCycles(6);
        checkOutput("0x3C write after busy falls", 32'(lastWrCyc - busyFallCyc), 32'd1);
        checkOutput("0x3C written value", 32'(lastWrData), 32'h3C);
        checkCounts("0x3C");

        $display("[TB] overrun: 0x11 then 0x22 behind busy");
        setBusy(1'b1);
        applyStimulus(8'h11, 1'b1, ^8'h11, -1, 1'b1);
        applyStimulus(8'h22, 1'b1, ^8'h22, -1, 1'b1);
        waitCycles(30);
        setBusy(1'b0);
        waitCycles(20);
        checkOutput("overrun keeps first byte", 32'(lastWrData), 32'h11);
        checkCounts("overrun");

        $display("[TB] 0x55 with stop bit low");
        applyStimulus(8'h55, 1'b0, ^8'h55, -1, 1'b1);
        checkCounts("framing");

        $display("[TB] 4-cycle glitch, then reset during bit 3 of 0xF0");
        @(posedge clk_in);
        #1;
        rx = 1'b0;
        waitCycles(4);
        rx = 1'b1;
        waitCycles(40);
        checkCounts("glitch");
        applyStimulus(8'hF0, 1'b1, ^8'hF0, 3, 1'b0);
        checkCounts("reset mid-frame");
        applyStimulus(8'h81, 1'b1, ^8'h81, -1, 1'b1);
        checkOutput("0x81 written value", 32'(lastWrData), 32'h81);
        checkCounts("0x81");

        if (ParityOn) begin
            $display("[TB] parity: 0x07 with odd then even parity");
            applyStimulus(8'h07, 1'b1, 1'b0, -1, 1'b1);
            checkCounts("bad parity");
            applyStimulus(8'h07, 1'b1, 1'b1, -1, 1'b1);
            checkOutput("0x07 written value", 32'(lastWrData), 32'h07);
            checkCounts("good parity");
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
